// File: rtl/traffic_phase_ctrl_if.sv
// Request inputs and light/status outputs of the traffic phase controller.
interface traffic_phase_ctrl_if #(
    parameter int unsigned N_APP = 3,
    parameter int unsigned CNT_W = 8
);
    logic               vip_req;
    logic [1:0]         vip_sel;
    logic               night_req;
    logic [1:0]         night_sel;
    logic [4*N_APP-1:0] car_traffic;
    logic [2*N_APP-1:0] walk_traffic;
    logic [1:0]         phase_idx;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   remaining;

    // Environment side: issues requests, observes lights.
    modport master (
        output vip_req, vip_sel, night_req, night_sel,
        input  car_traffic, walk_traffic, phase_idx, mode, remaining
    );

    // Controller side.
    modport slave (
        input  vip_req, vip_sel, night_req, night_sel,
        output car_traffic, walk_traffic, phase_idx, mode, remaining
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic light phase controller with VIP preemption and night mode.
module traffic_phase_ctrl #(
    parameter int unsigned N_APP    = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_LEFT   = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_FLASH  = 6,
    parameter int unsigned T_BLINK  = 2
) (
    input logic                  clk,
    input logic                  rst,
    traffic_phase_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_ENTER_Y = 3'd1;
    localparam logic [2:0] ST_VIP     = 3'd2;
    localparam logic [2:0] ST_NIGHT   = 3'd3;
    localparam logic [2:0] ST_EXIT_Y  = 3'd4;

    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_LEFT   = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;

    // Where a yellow transition lands once it is done.
    localparam logic [1:0] GO_VIP     = 2'd0;
    localparam logic [1:0] GO_NIGHT   = 2'd1;
    localparam logic [1:0] GO_RESTORE = 2'd2;
    localparam logic [1:0] GO_RESTART = 2'd3;

    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b1010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_DARK   = 4'b0000;
    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_OFF   = 2'b00;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(T_BLINK - 1);
    localparam logic [CNT_W-1:0] FLASH_LIM = CNT_W'(T_FLASH);
    localparam logic [1:0]       LAST_APP  = 2'(N_APP - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic             to_vip_q, to_vip_d;   // ENTER_Y heads to VIP (else NIGHT)
    logic             cancel_q, cancel_d;   // VIP dropped while still entering
    logic [1:0]       exit_q, exit_d;       // EXIT_Y landing
    logic             dark_q, dark_d;       // night blink half-period is DARK
    logic             sv_valid_q, sv_valid_d;
    logic [1:0]       sv_idx_q, sv_idx_d;
    logic [1:0]       sv_ph_q, sv_ph_d;
    logic [CNT_W-1:0] sv_cnt_q, sv_cnt_d;

    logic             go;
    logic [1:0]       go_kind;
    logic [1:0]       go_dest;
    logic [1:0]       req_tgt;
    logic [1:0]       vip_tgt;
    logic [1:0]       night_tgt;
    logic [1:0]       resume_kind;
    logic [CNT_W-1:0] cnt_dec;

    logic [4*N_APP-1:0] car;
    logic [2*N_APP-1:0] walk;

    function automatic logic [1:0] map_sel(input logic [1:0] sel);
        if (32'(sel) >= N_APP) begin
            return 2'd0;
        end
        return sel;
    endfunction

    assign vip_tgt   = map_sel(bus.vip_sel);
    assign night_tgt = map_sel(bus.night_sel);
    assign req_tgt   = bus.vip_req ? vip_tgt : night_tgt;
    assign cnt_dec   = cnt_q - CNT_W'(1);
    // After a VIP episode: stay dark if night is still wanted, else resume or restart.
    assign resume_kind = bus.night_req ? GO_NIGHT : (sv_valid_q ? GO_RESTORE : GO_RESTART);

    // Next-state logic: per-state decisions, then the shared landing actions.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        to_vip_d   = to_vip_q;
        cancel_d   = cancel_q;
        exit_d     = exit_q;
        dark_d     = dark_q;
        sv_valid_d = sv_valid_q;
        sv_idx_d   = sv_idx_q;
        sv_ph_d    = sv_ph_q;
        sv_cnt_d   = sv_cnt_q;
        go         = 1'b0;
        go_kind    = GO_RESTART;
        go_dest    = 2'd0;

        case (state_q)
            ST_RUN: begin
                if (bus.vip_req || bus.night_req) begin
                    sv_valid_d = 1'b1;
                    sv_idx_d   = idx_q;
                    sv_ph_d    = ph_q;
                    sv_cnt_d   = cnt_q;
                    tgt_d      = req_tgt;
                    to_vip_d   = bus.vip_req;
                    cancel_d   = 1'b0;
                    // Skip yellow if target already flows, or yellow just ran out.
                    if ((idx_q == req_tgt && ph_q != PH_YELLOW) ||
                        (ph_q == PH_YELLOW && cnt_q == '0)) begin
                        go      = 1'b1;
                        go_kind = bus.vip_req ? GO_VIP : GO_NIGHT;
                        go_dest = req_tgt;
                    end else begin
                        state_d = ST_ENTER_Y;
                        cnt_d   = (ph_q == PH_YELLOW) ? cnt_dec : LD_YELLOW;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else begin
                    case (ph_q)
                        PH_GREEN: begin
                            ph_d  = PH_LEFT;
                            cnt_d = LD_LEFT;
                        end
                        PH_LEFT: begin
                            ph_d  = PH_YELLOW;
                            cnt_d = LD_YELLOW;
                        end
                        default: begin
                            ph_d  = PH_GREEN;
                            cnt_d = LD_GREEN;
                            idx_d = (idx_q == LAST_APP) ? 2'd0 : idx_q + 2'd1;
                        end
                    endcase
                end
            end
            ST_ENTER_Y: begin
                cnt_d = cnt_dec;
                if (!to_vip_q && bus.vip_req) begin
                    tgt_d    = vip_tgt;
                    to_vip_d = 1'b1;
                end
                if (to_vip_q && !bus.vip_req) begin
                    cancel_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    go = 1'b1;
                    if (to_vip_q && (cancel_q || !bus.vip_req)) begin
                        go_kind = resume_kind;
                        go_dest = night_tgt;
                    end else if (to_vip_q) begin
                        go_kind = GO_VIP;
                        go_dest = tgt_q;
                    end else if (bus.vip_req) begin
                        go_kind = GO_VIP;
                        go_dest = vip_tgt;
                    end else begin
                        go_kind = GO_NIGHT;
                        go_dest = tgt_q;
                    end
                end
            end
            ST_VIP: begin
                if (!bus.vip_req) begin
                    state_d = ST_EXIT_Y;
                    cnt_d   = LD_YELLOW;
                    exit_d  = resume_kind;
                    tgt_d   = night_tgt;
                end
            end
            ST_NIGHT: begin
                if (bus.vip_req) begin
                    state_d  = ST_ENTER_Y;
                    cnt_d    = LD_YELLOW;
                    tgt_d    = vip_tgt;
                    to_vip_d = 1'b1;
                    cancel_d = 1'b0;
                end else if (!bus.night_req) begin
                    state_d = ST_EXIT_Y;
                    cnt_d   = LD_YELLOW;
                    exit_d  = GO_RESTART;
                end else if (cnt_q == '0) begin
                    cnt_d  = LD_BLINK;
                    dark_d = ~dark_q;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_EXIT_Y: begin
                cnt_d = cnt_dec;
                if (cnt_q == '0) begin
                    go      = 1'b1;
                    go_kind = exit_q;
                    go_dest = tgt_q;
                end
            end
            default: begin
                go      = 1'b1;
                go_kind = GO_RESTART;
            end
        endcase

        if (go) begin
            case (go_kind)
                GO_VIP: begin
                    state_d = ST_VIP;
                    idx_d   = go_dest;
                    cnt_d   = '0;
                end
                GO_NIGHT: begin
                    state_d    = ST_NIGHT;
                    idx_d      = go_dest;
                    cnt_d      = LD_BLINK;
                    dark_d     = 1'b0;
                    sv_valid_d = 1'b0;
                end
                GO_RESTORE: begin
                    state_d    = ST_RUN;
                    idx_d      = sv_idx_q;
                    ph_d       = sv_ph_q;
                    cnt_d      = sv_cnt_q;
                    sv_valid_d = 1'b0;
                end
                default: begin
                    state_d    = ST_RUN;
                    idx_d      = 2'd0;
                    ph_d       = PH_GREEN;
                    cnt_d      = LD_GREEN;
                    sv_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset to approach 0 GREEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            idx_q      <= 2'd0;
            ph_q       <= PH_GREEN;
            cnt_q      <= LD_GREEN;
            tgt_q      <= 2'd0;
            to_vip_q   <= 1'b0;
            cancel_q   <= 1'b0;
            exit_q     <= GO_RESTART;
            dark_q     <= 1'b0;
            sv_valid_q <= 1'b0;
            sv_idx_q   <= 2'd0;
            sv_ph_q    <= PH_GREEN;
            sv_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            to_vip_q   <= to_vip_d;
            cancel_q   <= cancel_d;
            exit_q     <= exit_d;
            dark_q     <= dark_d;
            sv_valid_q <= sv_valid_d;
            sv_idx_q   <= sv_idx_d;
            sv_ph_q    <= sv_ph_d;
            sv_cnt_q   <= sv_cnt_d;
        end
    end

    // Light decoding from the current state.
    always_comb begin
        car  = '0;
        walk = '0;
        for (int k = 0; k < int'(N_APP); k++) begin
            car[4*k +: 4]  = CAR_RED;
            walk[2*k +: 2] = WALK_RED;
            if (state_q == ST_NIGHT) begin
                car[4*k +: 4]  = dark_q ? CAR_DARK : CAR_RED;
                walk[2*k +: 2] = WALK_OFF;
            end
            if (idx_q == 2'(k)) begin
                case (state_q)
                    ST_RUN: begin
                        case (ph_q)
                            PH_GREEN: car[4*k +: 4] = CAR_GREEN;
                            PH_LEFT:  car[4*k +: 4] = CAR_LEFT;
                            default:  car[4*k +: 4] = CAR_YELLOW;
                        endcase
                    end
                    ST_VIP, ST_NIGHT: car[4*k +: 4] = CAR_GREEN;
                    default:          car[4*k +: 4] = CAR_YELLOW;
                endcase
            end
            // Crosswalk k runs beside approach k+1's green; flashes near its end.
            if (state_q == ST_RUN && ph_q == PH_GREEN && idx_q == 2'((k + 1) % N_APP)) begin
                walk[2*k +: 2] = (cnt_q < FLASH_LIM && !cnt_q[0]) ? WALK_OFF : WALK_GREEN;
            end
        end
    end

    assign bus.car_traffic  = car;
    assign bus.walk_traffic = walk;
    assign bus.phase_idx    = idx_q;
    assign bus.remaining    = cnt_q;
    assign bus.mode         = (state_q == ST_RUN)   ? 2'd0 :
                              (state_q == ST_VIP)   ? 2'd1 :
                              (state_q == ST_NIGHT) ? 2'd2 : 2'd3;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scoreboard bench for traffic_phase_ctrl (3 approaches, short timings).
module tb_traffic_phase_ctrl;
    localparam int unsigned N_APP = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] R = 4'b1000;
    localparam logic [3:0] Y = 4'b0100;
    localparam logic [3:0] L = 4'b1010;
    localparam logic [3:0] G = 4'b0001;
    localparam logic [3:0] D = 4'b0000;
    localparam logic [1:0] WR = 2'b10;
    localparam logic [1:0] WG = 2'b01;
    localparam logic [1:0] WO = 2'b00;

    typedef struct {
        int          cyc;
        int          id;
        logic [11:0] car;
        logic [5:0]  walk;
        logic [1:0]  idx;
        logic [1:0]  mode;
        logic [7:0]  rem;
    } exp_t;

    exp_t q[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   next_id = 0;
    int   checks = 0;
    int   errors = 0;

    traffic_phase_ctrl_if #(.N_APP(N_APP), .CNT_W(CNT_W)) bus ();

    traffic_phase_ctrl #(
        .N_APP(N_APP), .CNT_W(CNT_W), .T_GREEN(10), .T_LEFT(4),
        .T_YELLOW(3), .T_FLASH(3), .T_BLINK(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] car3(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [5:0] walk3(input logic [1:0] w0, input logic [1:0] w1,
                                         input logic [1:0] w2);
        return {w2, w1, w0};
    endfunction

    task automatic expect_at(input int d, input logic [11:0] car, input logic [5:0] walk,
                             input int idx, input int mode, input int rem);
        exp_t e;
        e.cyc  = base + d;
        e.id   = next_id;
        e.car  = car;
        e.walk = walk;
        e.idx  = 2'(idx);
        e.mode = 2'(mode);
        e.rem  = 8'(rem);
        next_id++;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every scheduled expectation on the falling edge of its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL chk%0d missed: due cycle %0d, now %0d", e.id, e.cyc, cyc);
                end else if (bus.car_traffic !== e.car || bus.walk_traffic !== e.walk ||
                             bus.phase_idx !== e.idx || bus.mode !== e.mode ||
                             bus.remaining !== e.rem) begin
                    errors++;
                    $display("FAIL chk%0d cyc %0d: got car=%b walk=%b idx=%0d mode=%0d rem=%0d, want car=%b walk=%b idx=%0d mode=%0d rem=%0d",
                             e.id, cyc, bus.car_traffic, bus.walk_traffic, bus.phase_idx,
                             bus.mode, bus.remaining, e.car, e.walk, e.idx, e.mode, e.rem);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        bus.vip_req   = 1'b0;
        bus.vip_sel   = 2'd0;
        bus.night_req = 1'b0;
        bus.night_sel = 2'd0;
        rst           = 1'b1;
        step(2);
        rst = 1'b0;

        // Free run over all three approaches.
        base = cyc;
        expect_at(0,  car3(G, R, R), walk3(WR, WR, WG), 0, 0, 9);
        expect_at(9,  car3(G, R, R), walk3(WR, WR, WO), 0, 0, 0);
        expect_at(10, car3(L, R, R), walk3(WR, WR, WR), 0, 0, 3);
        expect_at(14, car3(Y, R, R), walk3(WR, WR, WR), 0, 0, 2);
        expect_at(16, car3(Y, R, R), walk3(WR, WR, WR), 0, 0, 0);
        expect_at(17, car3(R, G, R), walk3(WG, WR, WR), 1, 0, 9);
        expect_at(24, car3(R, G, R), walk3(WO, WR, WR), 1, 0, 2);
        expect_at(25, car3(R, G, R), walk3(WG, WR, WR), 1, 0, 1);
        expect_at(26, car3(R, G, R), walk3(WO, WR, WR), 1, 0, 0);
        expect_at(34, car3(R, R, G), walk3(WR, WG, WR), 2, 0, 9);
        expect_at(51, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 9);
        step(54);

        // VIP to approach 2 from approach 0 GREEN remaining 6, then resume.
        base = cyc;
        expect_at(0,  car3(G, R, R), walk3(WR, WR, WG), 0, 0, 6);
        bus.vip_req = 1'b1;
        bus.vip_sel = 2'd2;
        expect_at(1,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 2);
        expect_at(2,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 1);
        expect_at(3,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 0);
        expect_at(4,  car3(R, R, G), walk3(WR, WR, WR), 2, 1, 0);
        expect_at(6,  car3(R, R, G), walk3(WR, WR, WR), 2, 1, 0);
        expect_at(7,  car3(R, R, Y), walk3(WR, WR, WR), 2, 3, 2);
        expect_at(9,  car3(R, R, Y), walk3(WR, WR, WR), 2, 3, 0);
        expect_at(10, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 6);
        expect_at(11, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 5);
        step(5);
        bus.vip_sel = 2'd1;
        step(1);
        bus.vip_req = 1'b0;
        step(11);

        // VIP on the approach already in LEFT: no entry yellow.
        base = cyc;
        expect_at(0, car3(L, R, R), walk3(WR, WR, WR), 0, 0, 3);
        bus.vip_req = 1'b1;
        bus.vip_sel = 2'd0;
        expect_at(1, car3(G, R, R), walk3(WR, WR, WR), 0, 1, 0);
        expect_at(2, car3(G, R, R), walk3(WR, WR, WR), 0, 1, 0);
        expect_at(3, car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 2);
        expect_at(5, car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 0);
        expect_at(6, car3(L, R, R), walk3(WR, WR, WR), 0, 0, 3);
        step(2);
        bus.vip_req = 1'b0;
        step(4);

        // Night mode on approach 1 with RED/DARK blinking, then restart.
        base = cyc;
        bus.night_req = 1'b1;
        bus.night_sel = 2'd1;
        expect_at(1,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 2);
        expect_at(3,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 0);
        expect_at(4,  car3(R, G, R), walk3(WO, WO, WO), 1, 2, 1);
        expect_at(5,  car3(R, G, R), walk3(WO, WO, WO), 1, 2, 0);
        expect_at(6,  car3(D, G, D), walk3(WO, WO, WO), 1, 2, 1);
        expect_at(7,  car3(D, G, D), walk3(WO, WO, WO), 1, 2, 0);
        expect_at(8,  car3(R, G, R), walk3(WO, WO, WO), 1, 2, 1);
        expect_at(9,  car3(R, Y, R), walk3(WR, WR, WR), 1, 3, 2);
        expect_at(11, car3(R, Y, R), walk3(WR, WR, WR), 1, 3, 0);
        expect_at(12, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 9);
        step(8);
        bus.night_req = 1'b0;
        step(4);

        // VIP and night together: VIP first, then night, then preempt and reset.
        base = cyc;
        expect_at(0, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 9);
        bus.vip_req   = 1'b1;
        bus.vip_sel   = 2'd2;
        bus.night_req = 1'b1;
        bus.night_sel = 2'd1;
        expect_at(1,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 2);
        expect_at(3,  car3(Y, R, R), walk3(WR, WR, WR), 0, 3, 0);
        expect_at(4,  car3(R, R, G), walk3(WR, WR, WR), 2, 1, 0);
        expect_at(5,  car3(R, R, Y), walk3(WR, WR, WR), 2, 3, 2);
        expect_at(7,  car3(R, R, Y), walk3(WR, WR, WR), 2, 3, 0);
        expect_at(8,  car3(R, G, R), walk3(WO, WO, WO), 1, 2, 1);
        expect_at(9,  car3(R, G, R), walk3(WO, WO, WO), 1, 2, 0);
        expect_at(10, car3(D, G, D), walk3(WO, WO, WO), 1, 2, 1);
        expect_at(11, car3(R, Y, R), walk3(WR, WR, WR), 1, 3, 2);
        expect_at(12, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 9);
        expect_at(13, car3(G, R, R), walk3(WR, WR, WG), 0, 0, 8);
        step(4);
        bus.vip_req = 1'b0;
        step(6);
        bus.vip_req = 1'b1;
        bus.vip_sel = 2'd0;
        step(1);
        rst = 1'b1;
        step(1);
        rst           = 1'b0;
        bus.vip_req   = 1'b0;
        bus.night_req = 1'b0;
        step(3);

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL leftover: %0d expectations never reached, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  N_APP, 3, number of approaches (2..4)
  CNT_W, 8, phase counter width
  T_GREEN, 20, through-green cycles
  T_LEFT, 10, protected-left cycles
  T_YELLOW, 3, yellow cycles
  T_FLASH, 6, walk-flash cycles at end of walk green
  T_BLINK, 2, night red-blink half-period cycles
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk, in, 1, single clock, all state on rising edge
  rst, in, 1, synchronous active-high reset
  vip_req, in, 1, VIP preemption request, level
  vip_sel, in, 2, VIP target approach
  night_req, in, 1, night mode request, level
  night_sel, in, 2, night main approach
  car_traffic, out, 4*N_APP, car light of approach k at [4k+3:4k]
  walk_traffic, out, 2*N_APP, walk light of crosswalk k at [2k+1:2k]
  phase_idx, out, 2, active approach
  mode, out, 2, 0 NORMAL, 1 VIP, 2 NIGHT, 3 TRANSITION
  remaining, out, CNT_W, phase counter value
REQ-003 SHALL encode car lights RED 1000, YELLOW 0100, LEFT 1010, GREEN 0001, DARK 0000; walk lights RED 10, GREEN 01, OFF 00.

Function
REQ-004 SHALL implement states RUN, ENTER_Y, VIP, NIGHT, EXIT_Y; mode = NORMAL in RUN, VIP in VIP, NIGHT in NIGHT, TRANSITION in ENTER_Y/EXIT_Y.
REQ-005 SHALL, in RUN, cycle the active approach through GREEN (T_GREEN) -> LEFT (T_LEFT) -> YELLOW (T_YELLOW); then approach idx+1, wrapping N_APP-1 -> 0; all other approaches RED.
REQ-006 SHALL load the counter with T-1 on phase entry and decrement each cycle; phase advances on the cycle after remaining == 0.
REQ-007 SHALL drive walk k GREEN during the GREEN phase of approach (k+1) mod N_APP, OFF when remaining < T_FLASH and remaining even; RED otherwise.
REQ-008 SHALL, in RUN, check vip_req before night_req each cycle; on a request, latch target (vip_sel or night_sel) and save phase_idx, phase and counter.
REQ-009 SHALL go straight to VIP/NIGHT, no yellow, when the active approach equals the target and is in GREEN or LEFT.
REQ-010 SHALL otherwise enter ENTER_Y: active approach YELLOW for T_YELLOW cycles, or for the remaining count if already in YELLOW; others RED; walks RED.
REQ-011 SHALL, in VIP, drive target GREEN, others RED, all walks RED; vip_sel changes ignored until exit.
REQ-012 SHALL, in NIGHT, drive target GREEN and all walks OFF; other approaches alternate RED/DARK every T_BLINK cycles, RED first.
REQ-013 SHALL, on vip_req fall in VIP, run EXIT_Y (VIP approach YELLOW, T_YELLOW cycles); then restore saved phase_idx, phase and counter exactly in RUN.
REQ-014 SHALL, on night_req fall in NIGHT, run EXIT_Y; then restart RUN at approach 0 GREEN, counter T_GREEN-1; saved state discarded.
REQ-015 SHALL, on vip_req rise in NIGHT, preempt via ENTER_Y on the night approach; on VIP exit go to NIGHT if night_req is high, else restart as REQ-014.
REQ-016 SHALL, on vip_req rise during a night ENTER_Y, retarget to vip_sel without restarting yellow; on vip_req fall during VIP ENTER_Y, finish yellow, then resume saved state with no extra yellow.
REQ-017 SHALL treat vip_sel/night_sel >= N_APP as 0.
REQ-018 SHALL require all T_* >= 1 and < 2**CNT_W; T_FLASH <= T_GREEN.

Reset
REQ-019 SHALL, while rst is high at a clock edge, set RUN, approach 0 GREEN, counter T_GREEN-1, others RED, walk N_APP-1 GREEN, other walks RED, mode 0, saved state cleared; rst mid-transition aborts it.

Verification
REQ-020 SHALL cover (N_APP=3, T_GREEN=10, T_LEFT=4, T_YELLOW=3, T_FLASH=3, T_BLINK=2):
  reset, free run 51 cycles -> approach 0 GREEN 10 cycles, LEFT 4, YELLOW 3, then approach 1 GREEN; back to approach 0 at cycle 51; walk 0 OFF/GREEN/OFF in approach-1 GREEN at remaining 2/1/0.
  vip_req=1, vip_sel=2 at approach 0 GREEN remaining 6 -> 3 YELLOW cycles, approach 2 GREEN; drop -> 3 YELLOW on approach 2, then approach 0 GREEN remaining 6.
  vip_req, vip_sel=0 during approach 0 LEFT -> VIP next cycle, no yellow, mode=1.
  night_req, night_sel=1 -> after yellow, approach 1 GREEN, approaches 0/2 RED 2, DARK 2, walks 00; drop -> yellow, approach 0 GREEN remaining 9.
  vip_req and night_req rise same cycle -> VIP wins; vip drop with night high -> NIGHT.
  rst pulse in ENTER_Y -> next cycle reset values of REQ-019.
